// File: rtl/prog_tick_divider.sv
// prog_tick_divider: N-channel runtime-programmable divider
// producing tick strobes and 50% square outputs.
module prog_tick_divider #(
  parameter int NUM_CH      = 4,
  parameter int COUNT_WIDTH = 24,
  parameter int DEFAULT_DIV = 12000000,
  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_CH-1:0]      en,
  input  logic                   sync,
  input  logic                   wr_en,
  input  logic [CHW-1:0]         wr_ch,
  input  logic [COUNT_WIDTH-1:0] wr_div,
  output logic [NUM_CH-1:0]      tick,
  output logic [NUM_CH-1:0]      sq,
  output logic [NUM_CH-1:0]      pend
);

  localparam logic [COUNT_WIDTH-1:0] DEF =
    COUNT_WIDTH'(DEFAULT_DIV);
  localparam logic [COUNT_WIDTH-1:0] ONE =
    COUNT_WIDTH'(1);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [COUNT_WIDTH-1:0] cnt;
    logic [COUNT_WIDTH-1:0] div;
    logic [COUNT_WIDTH-1:0] pdiv;
    logic [COUNT_WIDTH-1:0] deff;
    logic [COUNT_WIDTH-1:0] nxt_div;
    logic                   pend_q;
    logic                   tick_q;
    logic                   sq_q;
    logic                   hit;
    logic                   do_sync;
    logic                   do_off;
    logic                   do_term;

    always_comb begin
      deff    = (div == '0) ? ONE : div;
      hit     = wr_en && (int'(wr_ch) == c);
      do_sync = sync;
      do_off  = !sync && !en[c];
      do_term = !sync && en[c]
                && (cnt == deff - ONE);
      // a same-cycle write beats the queued one
      nxt_div = hit ? wr_div
              : (pend_q ? pdiv : div);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt    <= '0;
        div    <= DEF;
        pdiv   <= DEF;
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else begin
        if (hit) pdiv <= wr_div;
        unique case (1'b1)
          do_sync: begin
            cnt    <= '0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
            div    <= nxt_div;
            pend_q <= 1'b0;
          end
          do_off: begin
            cnt    <= '0;
            tick_q <= 1'b0;
            sq_q   <= 1'b0;
            // idle: older pending applies now,
            // a new write waits one cycle
            if (pend_q) div <= pdiv;
            pend_q <= hit;
          end
          do_term: begin
            cnt    <= '0;
            tick_q <= 1'b1;
            sq_q   <= ~sq_q;
            div    <= nxt_div;
            pend_q <= 1'b0;
          end
          default: begin
            cnt    <= cnt + ONE;
            tick_q <= 1'b0;
            if (hit) pend_q <= 1'b1;
          end
        endcase
      end
    end

    assign tick[c] = tick_q;
    assign sq[c]   = sq_q;
    assign pend[c] = pend_q;
  end

endmodule

// File: tb/tb_prog_tick_divider.sv
// tb_prog_tick_divider: random + directed bench
// against a time-based reference model.
module tb_prog_tick_divider;

  localparam int N   = 3;
  localparam int CW  = 8;
  localparam int DEF = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  en;
  logic          sync;
  logic          wr_en;
  logic [1:0]    wr_ch;
  logic [CW-1:0] wr_div;
  logic [N-1:0]  tick;
  logic [N-1:0]  sq;
  logic [N-1:0]  pend;

  prog_tick_divider #(
    .NUM_CH(N),
    .COUNT_WIDTH(CW),
    .DEFAULT_DIV(DEF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .sync(sync),
    .wr_en(wr_en),
    .wr_ch(wr_ch),
    .wr_div(wr_div),
    .tick(tick),
    .sq(sq),
    .pend(pend)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // model: active divisor, pending value and the
  // absolute edge index at which the next tick lands
  int  n = 0;
  int  md[N];
  int  mpv[N];
  int  mterm[N];
  bit  mpf[N];
  bit  mt[N];
  bit  ms[N];
  bit  valid = 1'b0;
  bit  hit;
  logic [N-1:0] et;
  logic [N-1:0] es;
  logic [N-1:0] ep;

  function automatic int eff(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic check(input string name,
                       input logic [N-1:0] act,
                       input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b edge %0d",
               name, act, exp, n);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      n++;
      for (int c = 0; c < N; c++) begin
        hit = wr_en && (int'(wr_ch) == c);
        if (rst) begin
          md[c] = DEF; mpv[c] = DEF; mpf[c] = 0;
          mt[c] = 0; ms[c] = 0;
          mterm[c] = n + DEF;
        end else if (sync) begin
          if (hit) md[c] = int'(wr_div);
          else if (mpf[c]) md[c] = mpv[c];
          if (hit) mpv[c] = int'(wr_div);
          mpf[c] = 0; mt[c] = 0; ms[c] = 0;
          mterm[c] = n + eff(md[c]);
        end else if (!en[c]) begin
          if (mpf[c]) md[c] = mpv[c];
          mpf[c] = hit;
          if (hit) mpv[c] = int'(wr_div);
          mt[c] = 0; ms[c] = 0;
          mterm[c] = n + eff(md[c]);
        end else if (n == mterm[c]) begin
          mt[c] = 1; ms[c] = ~ms[c];
          if (hit) md[c] = int'(wr_div);
          else if (mpf[c]) md[c] = mpv[c];
          if (hit) mpv[c] = int'(wr_div);
          mpf[c] = 0;
          mterm[c] = n + eff(md[c]);
        end else begin
          mt[c] = 0;
          if (hit) begin
            mpv[c] = int'(wr_div);
            mpf[c] = 1;
          end
        end
      end
      if (rst) valid = 1'b1;
      #1;
      if (valid) begin
        for (int c = 0; c < N; c++) begin
          et[c] = mt[c];
          es[c] = ms[c];
          ep[c] = mpf[c];
        end
        check("model tick", tick, et);
        check("model sq", sq, es);
        check("model pend", pend, ep);
      end
    end
  end

  initial begin
    rst = 1'b1; en = '0; sync = 1'b0;
    wr_en = 1'b0; wr_ch = '0; wr_div = '0;
    repeat (2) @(negedge clk);
    check("reset tick", tick, '0);
    check("reset sq", sq, '0);
    check("reset pend", pend, '0);
    rst = 1'b0; en = '1;

    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      check("boot tick", tick,
            (k % 5 == 0) ? {N{1'b1}} : '0);
      check("boot sq", sq,
            ((k / 5) % 2 == 1) ? {N{1'b1}} : '0);
    end

    repeat (2) @(negedge clk);
    wr_en = 1'b1; wr_ch = 2'd0; wr_div = 8'd3;
    @(negedge clk);
    wr_en = 1'b0;
    check("wr pend", pend, 3'b001);
    @(negedge clk);
    check("wr wait tick", tick, 3'b000);
    check("wr wait pend", pend, 3'b001);
    @(negedge clk);
    check("swap tick", tick, 3'b111);
    check("swap pend", pend, 3'b000);
    repeat (3) @(negedge clk);
    check("d3 tick", tick, 3'b001);
    repeat (2) @(negedge clk);
    check("d5 tick", tick, 3'b110);

    wr_en = 1'b1; wr_ch = 2'd2; wr_div = 8'd0;
    @(negedge clk);
    wr_en = 1'b0;
    check("d0 pend", pend, 3'b100);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    check("sync tick", tick, 3'b000);
    check("sync sq", sq, 3'b000);
    check("sync pend", pend, 3'b000);
    @(negedge clk);
    check("sync+1", tick, 3'b100);
    @(negedge clk);
    check("sync+2", tick, 3'b100);
    @(negedge clk);
    check("sync+3", tick, 3'b101);
    @(negedge clk);
    check("sync+4", tick, 3'b100);
    @(negedge clk);
    check("sync+5", tick, 3'b110);

    wr_en = 1'b1; wr_ch = 2'd3; wr_div = 8'd1;
    @(negedge clk);
    wr_en = 1'b0;
    check("bad ch pend", pend, 3'b000);

    for (int i = 0; i < 3000; i++) begin
      wr_en  = ($urandom_range(0, 3) == 0);
      wr_ch  = 2'($urandom_range(0, 3));
      wr_div = CW'($urandom_range(0, 9));
      sync   = ($urandom_range(0, 60) == 0);
      rst    = ($urandom_range(0, 400) == 0);
      if ($urandom_range(0, 14) == 0)
        en = en ^ N'(1 << $urandom_range(0, N - 1));
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
